// File: rtl/simd_alu_issuer_pkg.sv
// Shared SIMD definitions: opcode encoding, widths, issuer FSM states and
// the opcode legality check used by the command issuer.
package simd_alu_issuer_pkg;

    localparam int SIMD_OPC_WIDTH  = 6;
    localparam int SIMD_DATA_WIDTH = 256;

    typedef logic [SIMD_OPC_WIDTH-1:0] simd_opc_t;

    typedef enum logic [2:0] {
        OP_ADD, OP_S_ADD, OP_SUB, OP_S_SUB, OP_LSL, OP_LSR, OP_CMP, OP_GT
    } simd_op_e;

    typedef enum logic [1:0] {
        LANE_8, LANE_16, LANE_32, LANE_64
    } simd_lane_e;

    typedef enum logic [1:0] {
        ST_IDLE, ST_DRIVE, ST_CAPTURE
    } issuer_state_e;

    // Opcode = {1'b0, operation[2:0], lane size[1:0]}; codes with the MSB set are illegal.
    localparam simd_opc_t SIMD_ADD8   = 6'h00, SIMD_ADD16   = 6'h01, SIMD_ADD32   = 6'h02, SIMD_ADD64   = 6'h03;
    localparam simd_opc_t SIMD_S_ADD8 = 6'h04, SIMD_S_ADD16 = 6'h05, SIMD_S_ADD32 = 6'h06, SIMD_S_ADD64 = 6'h07;
    localparam simd_opc_t SIMD_SUB8   = 6'h08, SIMD_SUB16   = 6'h09, SIMD_SUB32   = 6'h0A, SIMD_SUB64   = 6'h0B;
    localparam simd_opc_t SIMD_S_SUB8 = 6'h0C, SIMD_S_SUB16 = 6'h0D, SIMD_S_SUB32 = 6'h0E, SIMD_S_SUB64 = 6'h0F;
    localparam simd_opc_t SIMD_LSL8   = 6'h10, SIMD_LSL16   = 6'h11, SIMD_LSL32   = 6'h12, SIMD_LSL64   = 6'h13;
    localparam simd_opc_t SIMD_LSR8   = 6'h14, SIMD_LSR16   = 6'h15, SIMD_LSR32   = 6'h16, SIMD_LSR64   = 6'h17;
    localparam simd_opc_t SIMD_CMP8   = 6'h18, SIMD_CMP16   = 6'h19, SIMD_CMP32   = 6'h1A, SIMD_CMP64   = 6'h1B;
    localparam simd_opc_t SIMD_GT8    = 6'h1C, SIMD_GT16    = 6'h1D, SIMD_GT32    = 6'h1E, SIMD_GT64    = 6'h1F;

    function automatic logic simd_opc_legal(input simd_opc_t opc);
        return opc < simd_opc_t'(32);
    endfunction

endpackage

// File: rtl/simd_alu_issuer_if.sv
// Command and response handshake bundle between a requester and the SIMD ALU issuer.
interface simd_alu_issuer_if #(
    parameter int DATA_WIDTH = 256,
    parameter int TAG_WIDTH  = 4
);
    logic                               cmd_valid;
    logic                               cmd_ready;
    simd_alu_issuer_pkg::simd_opc_t     cmd_opcode;
    logic [DATA_WIDTH-1:0]              cmd_a;
    logic [DATA_WIDTH-1:0]              cmd_b;
    logic [TAG_WIDTH-1:0]               cmd_tag;

    logic                               rsp_valid;
    logic                               rsp_ready;
    logic [DATA_WIDTH-1:0]              rsp_data;
    logic [DATA_WIDTH/8-1:0]            rsp_ovf;
    logic [DATA_WIDTH/8-1:0]            rsp_udf;
    logic [TAG_WIDTH-1:0]               rsp_tag;
    logic                               rsp_err;

    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_ovf, rsp_udf, rsp_tag, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_ovf, rsp_udf, rsp_tag, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/simd_alu_issuer_rsp_fifo.sv
// First-word-fall-through response FIFO; the head entry is always visible on rd_data_o.
module simd_alu_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_wr;
    logic             do_rd;

    assign do_rd     = rd_en_i && (count_q != '0);
    assign do_wr     = wr_en_i && ((count_q != CW'(DEPTH)) || do_rd);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/simd_alu_issuer.sv
// Issues commands to a registered-operand SIMD ALU one at a time and queues the
// results (or an error entry for illegal opcodes) in a response FIFO.
module simd_alu_issuer
    import simd_alu_issuer_pkg::*;
#(
    parameter int DATA_WIDTH = SIMD_DATA_WIDTH,
    parameter int TAG_WIDTH  = 4,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    simd_alu_issuer_if.slave         bus,
    output simd_opc_t                alu_opcode_o,
    output logic [DATA_WIDTH-1:0]    alu_a_o,
    output logic [DATA_WIDTH-1:0]    alu_b_o,
    input  logic [DATA_WIDTH-1:0]    alu_out_i,
    input  logic [DATA_WIDTH/8-1:0]  alu_ovf_i,
    input  logic [DATA_WIDTH/8-1:0]  alu_udf_i,
    output logic                     busy_o
);
    localparam int FW = DATA_WIDTH / 8;
    localparam int RW = DATA_WIDTH + 2 * FW + TAG_WIDTH + 1;
    localparam int CW = $clog2(RSP_DEPTH) + 1;

    issuer_state_e           state_q;
    simd_opc_t               opc_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic [TAG_WIDTH-1:0]    tag_q;

    logic                    cmd_ready;
    logic                    cmd_fire;
    logic                    cmd_legal;
    logic                    fifo_wr;
    logic [RW-1:0]           fifo_wdata;
    logic [RW-1:0]           fifo_rdata;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_count;
    logic                    rsp_vis;
    logic [RW-1:0]           rsp_word;

    // Each in-flight operation reserves a FIFO slot so CAPTURE can never overflow it.
    assign cmd_ready = !rst && (state_q == ST_IDLE)
                       && ((fifo_count + CW'(state_q != ST_IDLE)) < CW'(RSP_DEPTH));
    assign cmd_fire  = cmd_ready && bus.cmd_valid;
    assign cmd_legal = simd_opc_legal(bus.cmd_opcode);

    assign bus.cmd_ready = cmd_ready;
    assign alu_opcode_o  = opc_q;
    assign alu_a_o       = a_q;
    assign alu_b_o       = b_q;
    assign busy_o        = !rst && ((state_q != ST_IDLE) || !fifo_empty);

    assign fifo_wr    = !rst && ((state_q == ST_CAPTURE) || (cmd_fire && !cmd_legal));
    assign fifo_wdata = (state_q == ST_CAPTURE)
                        ? {alu_out_i, alu_ovf_i, alu_udf_i, tag_q, 1'b0}
                        : {{(DATA_WIDTH + 2 * FW){1'b0}}, bus.cmd_tag, 1'b1};

    assign rsp_vis   = !rst && !fifo_empty;
    assign rsp_word  = rsp_vis ? fifo_rdata : '0;
    assign bus.rsp_valid = rsp_vis;
    assign {bus.rsp_data, bus.rsp_ovf, bus.rsp_udf, bus.rsp_tag, bus.rsp_err} = rsp_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            opc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_fire && cmd_legal) begin
                        opc_q   <= bus.cmd_opcode;
                        a_q     <= bus.cmd_a;
                        b_q     <= bus.cmd_b;
                        tag_q   <= bus.cmd_tag;
                        state_q <= ST_DRIVE;
                    end
                end
                ST_DRIVE:   state_q <= ST_CAPTURE;
                ST_CAPTURE: state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    simd_alu_rsp_fifo #(
        .WIDTH (RW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (fifo_wr),
        .wr_data_i (fifo_wdata),
        .rd_en_i   (rsp_vis && bus.rsp_ready),
        .rd_data_o (fifo_rdata),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );
endmodule

// File: tb/tb_simd_alu_issuer.sv
// Scoreboard bench for simd_alu_issuer with a behavioural lane-wise ALU.
module tb_simd_alu_issuer;
    import simd_alu_issuer_pkg::*;

    localparam int DW = 256;
    localparam int TW = 4;
    localparam int FW = DW / 8;
    localparam int RW = DW + 2 * FW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    simd_alu_issuer_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus();

    simd_opc_t       alu_opcode;
    logic [DW-1:0]   alu_a, alu_b, alu_out, a_r, b_r;
    logic [FW-1:0]   alu_ovf, alu_udf;
    logic            busy;

    simd_alu_issuer #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .RSP_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .alu_opcode_o (alu_opcode),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_out_i    (alu_out),
        .alu_ovf_i    (alu_ovf),
        .alu_udf_i    (alu_udf),
        .busy_o       (busy)
    );

    // Lane-wise reference arithmetic; also serves as the ALU the DUT drives.
    function automatic logic [RW-1:0] alu_ref(input simd_opc_t opc, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [DW-1:0] r = '0;
        logic [FW-1:0] ov = '0, ud = '0;
        int w, nb, sh;
        logic [63:0] mask, x, y, z;
        logic [64:0] s;
        logic signed [65:0] xs, ys, ss, smax, smin;
        logic o, u;
        w    = 8 << opc[1:0];
        nb   = w / 8;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        smax = (66'sd1 <<< (w - 1)) - 66'sd1;
        smin = -(66'sd1 <<< (w - 1));
        for (int l = 0; l < DW / w; l++) begin
            x  = 64'(a >> (l * w)) & mask;
            y  = 64'(b >> (l * w)) & mask;
            xs = x[w-1] ? $signed({2'b00, x}) - $signed(66'd1 << w) : $signed({2'b00, x});
            ys = y[w-1] ? $signed({2'b00, y}) - $signed(66'd1 << w) : $signed({2'b00, y});
            z = '0; o = 1'b0; u = 1'b0;
            sh = int'(y % 64'(w));
            case (opc[4:2])
                3'd0: begin s = {1'b0, x} + {1'b0, y}; z = s[63:0]; o = s[w]; end
                3'd1: begin ss = xs + ys; z = ss[63:0]; o = ss > smax; u = ss < smin; end
                3'd2: begin z = x - y; u = x < y; end
                3'd3: begin ss = xs - ys; z = ss[63:0]; o = ss > smax; u = ss < smin; end
                3'd4: z = x << sh;
                3'd5: z = x >> sh;
                3'd6: z = (x == y) ? mask : '0;
                default: z = (x > y) ? mask : '0;
            endcase
            z = z & mask;
            r = r | (DW'(z) << (l * w));
            for (int k = 0; k < nb; k++) begin
                ov[l * nb + k] = o;
                ud[l * nb + k] = u;
            end
        end
        return {r, ov, ud};
    endfunction

    always @(posedge clk) begin
        a_r <= alu_a;
        b_r <= alu_b;
    end
    assign {alu_out, alu_ovf, alu_udf} = alu_ref(alu_opcode, a_r, b_r);

    typedef struct {
        logic [DW-1:0] data;
        logic [FW-1:0] ovf;
        logic [FW-1:0] udf;
        logic [TW-1:0] tag;
        logic          err;
        int            acc;
        int            lat;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rdy_mode = 0;
    simd_opc_t last_opc = '0;
    logic [DW-1:0] last_a = '0, last_b = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: drives rsp_ready, checks stall stability and pops the scoreboard.
    logic tgl = 1'b0;
    bit prev_stall = 0;
    logic [RW+TW:0] prev_word;
    always @(negedge clk) begin
        logic [RW+TW:0] word;
        exp_t e;
        case (rdy_mode)
            0: bus.rsp_ready = 1'b1;
            1: bus.rsp_ready = 1'b0;
            2: begin tgl = ~tgl; bus.rsp_ready = tgl; end
            default: bus.rsp_ready = 1'($urandom % 2);
        endcase
        word = {bus.rsp_data, bus.rsp_ovf, bus.rsp_udf, bus.rsp_tag, bus.rsp_err};
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) chk("hold", {bus.rsp_valid, word}, {1'b1, prev_word});
            prev_stall = bus.rsp_valid && !bus.rsp_ready;
            prev_word  = word;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp actual=tag%0d err%0b required=none", bus.rsp_tag, bus.rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    $display("rsp tag=%0d err=%0b ovf=%h udf=%h data=%h", bus.rsp_tag, bus.rsp_err,
                             bus.rsp_ovf, bus.rsp_udf, bus.rsp_data);
                    chk("rsp", word, {e.data, e.ovf, e.udf, e.tag, e.err});
                    if (e.lat > 0) chk("latency", cyc - e.acc, e.lat);
                end
            end
        end
    end

    function automatic logic [DW-1:0] rvec();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic send(input simd_opc_t opc, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [TW-1:0] tag, input bit push, input int lat, input int budget,
                        output bit ok);
        exp_t e;
        int n = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_opcode = opc; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_tag = tag;
        while (!bus.cmd_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = bus.cmd_ready;
        if (ok) begin
            if (opc < 32) begin
                {e.data, e.ovf, e.udf} = alu_ref(opc, a, b);
                last_opc = opc; last_a = a; last_b = b;
            end else begin
                e.data = '0; e.ovf = '0; e.udf = '0;
            end
            e.tag = tag; e.err = (opc >= 32); e.acc = cyc; e.lat = lat;
            if (push) exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
    endtask

    // Hand-written expectation for a command accepted on the edge just passed.
    task automatic push_dir(input logic [DW-1:0] d, input logic [FW-1:0] ov, input logic [FW-1:0] ud,
                            input logic [TW-1:0] tag, input int lat);
        exp_t e;
        e.data = d; e.ovf = ov; e.udf = ud; e.tag = tag; e.err = 1'b0; e.acc = cyc - 1; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_%s actual=%0d pending required=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_ctl"}, {bus.cmd_ready, bus.rsp_valid, busy}, 0);
        chk({name, "_rsp"}, {bus.rsp_data, bus.rsp_ovf, bus.rsp_udf, bus.rsp_tag, bus.rsp_err}, 0);
        chk({name, "_aluopc"}, alu_opcode, 0);
        chk({name, "_alua"}, alu_a, 0);
        chk({name, "_alub"}, alu_b, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        simd_opc_t s4_ops[3];
        bus.cmd_valid = 0; bus.cmd_opcode = '0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_tag = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // ADD8 overflow in every byte lane
        send(SIMD_ADD8, {32{8'hFF}}, {32{8'h01}}, 4'd3, 0, 0, 20, ok);
        push_dir('0, '1, '0, 4'd3, 3);
        drain("s1");

        // Illegal opcode: error entry after one cycle, ALU inputs untouched
        send(6'h2A, rvec(), rvec(), 4'd5, 1, 1, 20, ok);
        drain("s2");
        chk("s2_aluopc", alu_opcode, last_opc);
        chk("s2_alua", alu_a, last_a);
        chk("s2_alub", alu_b, last_b);

        // SUB64 borrow in every lane, opcode stable through DRIVE and CAPTURE
        send(SIMD_SUB64, {4{64'd1}}, {4{64'd2}}, 4'd6, 0, 0, 20, ok);
        push_dir('1, '0, '1, 4'd6, 3);
        @(negedge clk);
        chk("s6_drive_opc", alu_opcode, SIMD_SUB64);
        chk("s6_drive_a", alu_a, {4{64'd1}});
        @(negedge clk);
        chk("s6_capture_opc", alu_opcode, SIMD_SUB64);
        drain("s6");

        // Back-pressure: four fill the buffer, the fifth must be refused
        rdy_mode = 1;
        for (int i = 0; i < 4; i++) begin
            send(simd_opc_t'($urandom_range(0, 31)), rvec(), rvec(), TW'(i), 1, 0, 20, ok);
            chk("s3_accept", ok, 1);
        end
        send(SIMD_ADD16, rvec(), rvec(), 4'd4, 1, 0, 20, ok);
        chk("s3_block", ok, 0);
        chk("s3_ready", {bus.cmd_ready, busy}, 2'b01);
        rdy_mode = 0;
        send(SIMD_ADD16, rvec(), rvec(), 4'd4, 1, 0, 40, ok);
        send(SIMD_S_SUB8, rvec(), rvec(), 4'd5, 1, 0, 40, ok);
        drain("s3");

        // Toggling rsp_ready during back-to-back LSL16/GT32/CMP64
        rdy_mode = 2;
        s4_ops[0] = SIMD_LSL16; s4_ops[1] = SIMD_GT32; s4_ops[2] = SIMD_CMP64;
        for (int i = 0; i < 12; i++) begin
            logic [DW-1:0] va;
            va = rvec();
            send(s4_ops[i % 3], va, (i % 2 == 0) ? va : rvec(), TW'(i), 1, 0, 40, ok);
        end
        drain("s4");

        // Random opcodes (about a quarter illegal) with random back-pressure
        rdy_mode = 3;
        for (int i = 0; i < 40; i++) begin
            simd_opc_t op;
            op = ($urandom % 4 == 0) ? simd_opc_t'($urandom_range(32, 63))
                                     : simd_opc_t'($urandom_range(0, 31));
            send(op, rvec(), rvec(), TW'($urandom), 1, 0, 60, ok);
        end
        drain("rand");

        // Reset during CAPTURE discards the operation
        rdy_mode = 0;
        send(SIMD_ADD32, rvec(), rvec(), 4'd9, 0, 0, 20, ok);
        @(negedge clk);
        @(negedge clk);
        chk("s5_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check_zero("s5");
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("s5_norsp", bus.rsp_valid, 0);
        chk("idle_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
